// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the single-issue PC sequencer.
// Holds the control-state encoding and the datapath widths used by every file.
package pc_sequencer_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] PC_INCREMENT = 64'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        EXEC
    } state_t;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Next-PC arithmetic: sequential step or PC-relative branch target.
// All additions wrap modulo 2^64; the word offset loses its top two bits.
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    input  logic            branch,
    input  logic            uncondbranch,
    input  logic            alu_zero,
    output logic [PC_W-1:0] next_pc
);

    logic            taken;
    logic [PC_W-1:0] offset;

    assign taken   = uncondbranch | (branch & alu_zero);
    // Word offset to byte offset; a negative immediate becomes a two's-complement add.
    assign offset  = taken ? {imm[PC_W-3:0], 2'b00} : PC_INCREMENT;
    assign next_pc = pc + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/resolve sequencer keeping exactly one instruction in flight.
// Loop is REQ -> WAIT -> HOLD -> EXEC, with IDLE only after reset.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic              CLK,
    input  logic              Reset_L,
    output logic              IMemReq,
    output logic [PC_W-1:0]   IMemAddr,
    input  logic              IMemGnt,
    input  logic              IMemRspValid,
    input  logic [INST_W-1:0] IMemRspData,
    output logic              InstValid,
    output logic [INST_W-1:0] Instruction,
    output logic [PC_W-1:0]   InstPC,
    input  logic              InstReady,
    input  logic              ResolveValid,
    input  logic              Branch,
    input  logic              Uncondbranch,
    input  logic              ALUZero,
    input  logic [PC_W-1:0]   SignExtImm64,
    output logic [31:0]       RetireCount
);

    state_t              state_reg;
    state_t              state_next;
    logic [PC_W-1:0]     pc_reg;
    logic [INST_W-1:0]   instruction_reg;
    logic [PC_W-1:0]     inst_pc_reg;
    logic [31:0]         retire_count_reg;
    logic [PC_W-1:0]     next_pc;
    logic                capture_rsp;
    logic                resolve;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_reg),
        .imm          (SignExtImm64),
        .branch       (Branch),
        .uncondbranch (Uncondbranch),
        .alu_zero     (ALUZero),
        .next_pc      (next_pc)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Each handshake input is only looked at in the one state that owns it.
    always_comb begin
        state_next  = state_reg;
        capture_rsp = 1'b0;
        resolve     = 1'b0;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (IMemGnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (IMemRspValid) begin
                    capture_rsp = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (InstReady) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (ResolveValid) begin
                    resolve    = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc_reg           <= RESET_PC;
            instruction_reg  <= '0;
            inst_pc_reg      <= RESET_PC;
            retire_count_reg <= '0;
        end else begin
            if (capture_rsp) begin
                instruction_reg <= IMemRspData;
                inst_pc_reg     <= pc_reg;
            end
            if (resolve) begin
                pc_reg           <= next_pc;
                retire_count_reg <= retire_count_reg + 32'd1;
            end
        end
    end

    assign IMemReq     = (state_reg == REQ);
    assign IMemAddr    = pc_reg;
    assign InstValid   = (state_reg == HOLD);
    assign Instruction = instruction_reg;
    assign InstPC      = inst_pc_reg;
    assign RetireCount = retire_count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: fetch addresses and instructions are
// queued when stimulus is driven and compared when the sequencer presents them.
module tb_pc_sequencer;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRspValid;
    logic [31:0] IMemRspData;
    logic        InstValid;
    logic [31:0] Instruction;
    logic [63:0] InstPC;
    logic        InstReady;
    logic        ResolveValid;
    logic        Branch;
    logic        Uncondbranch;
    logic        ALUZero;
    logic [63:0] SignExtImm64;
    logic [31:0] RetireCount;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] addr_q[$];
    logic [31:0] inst_q[$];
    logic [31:0] exp_retire;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemGnt      (IMemGnt),
        .IMemRspValid (IMemRspValid),
        .IMemRspData  (IMemRspData),
        .InstValid    (InstValid),
        .Instruction  (Instruction),
        .InstPC       (InstPC),
        .InstReady    (InstReady),
        .ResolveValid (ResolveValid),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUZero      (ALUZero),
        .SignExtImm64 (SignExtImm64),
        .RetireCount  (RetireCount)
    );

    always #5 CLK = ~CLK;

    // One full instruction: fetch, response, decode handshake, resolve.
    task automatic do_instr(input logic br, input logic ub, input logic az,
                            input logic [63:0] imm, input int gnt_wait,
                            input int resp_wait, input logic spurious);
        logic [63:0] exp_addr;
        logic [63:0] npc;
        logic [31:0] data;
        logic [31:0] exp_inst;
        int          n;
        n = 0;
        while (IMemReq !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (IMemReq !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: IMemReq=%b required 1", IMemReq);
            return;
        end
        exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 64'hX;
        checks++;
        if (IMemAddr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_addr: IMemAddr=%h required %h", IMemAddr, exp_addr);
        end
        for (int i = 0; i < gnt_wait; i++) begin
            IMemGnt      = 1'b0;
            IMemRspValid = spurious;
            IMemRspData  = $urandom;
            @(negedge CLK);
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== exp_addr) begin
                errors++;
                $display("FAIL req_stable: cycle %0d IMemReq=%b IMemAddr=%h required 1 %h",
                         i, IMemReq, IMemAddr, exp_addr);
            end
        end
        IMemGnt      = 1'b1;
        IMemRspValid = spurious;
        IMemRspData  = $urandom;
        @(negedge CLK);
        IMemGnt      = 1'b0;
        IMemRspValid = 1'b0;
        checks++;
        if (IMemReq !== 1'b0 || InstValid !== 1'b0) begin
            errors++;
            $display("FAIL after_grant: IMemReq=%b InstValid=%b required 0 0", IMemReq, InstValid);
        end
        for (int i = 0; i < resp_wait; i++) begin
            @(negedge CLK);
            checks++;
            if (InstValid !== 1'b0) begin
                errors++;
                $display("FAIL wait_valid: InstValid=%b required 0", InstValid);
            end
        end
        data         = $urandom;
        IMemRspValid = 1'b1;
        IMemRspData  = data;
        inst_q.push_back(data);
        @(negedge CLK);
        IMemRspValid = 1'b0;
        IMemRspData  = $urandom;
        exp_inst     = inst_q.pop_front();
        checks++;
        if (InstValid !== 1'b1 || Instruction !== exp_inst || InstPC !== exp_addr) begin
            errors++;
            $display("FAIL hold: InstValid=%b Instruction=%h InstPC=%h required 1 %h %h",
                     InstValid, Instruction, InstPC, exp_inst, exp_addr);
        end
        InstReady = 1'b1;
        if (spurious) begin
            ResolveValid = 1'b1;
            Uncondbranch = 1'b1;
            SignExtImm64 = 64'h40;
        end
        @(negedge CLK);
        InstReady    = 1'b0;
        ResolveValid = 1'b0;
        Uncondbranch = 1'b0;
        checks++;
        if (InstValid !== 1'b0 || RetireCount !== exp_retire) begin
            errors++;
            $display("FAIL exec_entry: InstValid=%b RetireCount=%0d required 0 %0d",
                     InstValid, RetireCount, exp_retire);
        end
        if (spurious) begin
            IMemRspValid = 1'b1;
            IMemRspData  = ~exp_inst;
            InstReady    = 1'b1;
            @(negedge CLK);
            IMemRspValid = 1'b0;
            InstReady    = 1'b0;
            checks++;
            if (Instruction !== exp_inst || IMemReq !== 1'b0 || InstValid !== 1'b0) begin
                errors++;
                $display("FAIL exec_ignore: Instruction=%h IMemReq=%b InstValid=%b required %h 0 0",
                         Instruction, IMemReq, InstValid, exp_inst);
            end
        end
        ResolveValid = 1'b1;
        Branch       = br;
        Uncondbranch = ub;
        ALUZero      = az;
        SignExtImm64 = imm;
        npc = exp_addr + ((ub | (br & az)) ? (imm << 2) : 64'd4);
        addr_q.push_back(npc);
        exp_retire++;
        @(negedge CLK);
        ResolveValid = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        ALUZero      = 1'b0;
        SignExtImm64 = '0;
        checks++;
        if (RetireCount !== exp_retire) begin
            errors++;
            $display("FAIL retire: RetireCount=%0d required %0d", RetireCount, exp_retire);
        end
        $display("instr pc=%h inst=%h br=%b ub=%b az=%b imm=%h next=%h retire=%0d",
                 exp_addr, exp_inst, br, ub, az, imm, npc, RetireCount);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (IMemReq !== 1'b0 || InstValid !== 1'b0 || Instruction !== 32'h0 ||
            InstPC !== RESET_PC || RetireCount !== 32'h0) begin
            errors++;
            $display("FAIL %s: req=%b valid=%b inst=%h ipc=%h retire=%0d required 0 0 0 %h 0",
                     tag, IMemReq, InstValid, Instruction, InstPC, RetireCount, RESET_PC);
        end
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        IMemGnt = 1'b0; IMemRspValid = 1'b0; IMemRspData = '0;
        InstReady = 1'b0; ResolveValid = 1'b0;
        Branch = 1'b0; Uncondbranch = 1'b0; ALUZero = 1'b0; SignExtImm64 = '0;
        exp_retire = '0;
        #1;
        check_reset_outputs("reset_async");
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset_held");
        Reset_L = 1'b1;
        #1;
        checks++;
        if (IMemReq !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: IMemReq=%b required 0", IMemReq);
        end
        addr_q.push_back(RESET_PC);
        $display("reset released, first fetch expected at %h", RESET_PC);
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) do_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 1'b0);
    endtask

    task automatic test_branches();
        do_instr(1'b0, 1'b1, 1'b0, 64'd61, 0, 0, 1'b0);                   // 0xC -> 0x100
        do_instr(1'b0, 1'b1, 1'b0, 64'h10, 0, 0, 1'b0);                   // -> 0x140
        do_instr(1'b0, 1'b1, 1'b1, -64'sd16, 0, 1, 1'b0);                 // -> 0x100
        do_instr(1'b1, 1'b0, 1'b0, -64'sd2, 0, 0, 1'b0);                  // not taken -> 0x104
        do_instr(1'b1, 1'b0, 1'b1, -64'sd1, 0, 0, 1'b0);                  // -> 0x100
        do_instr(1'b1, 1'b0, 1'b1, -64'sd2, 0, 0, 1'b0);                  // -> 0xF8
        do_instr(1'b0, 1'b0, 1'b1, 64'd5, 0, 0, 1'b0);                    // zero alone: -> 0xFC
    endtask

    task automatic test_stall_spurious();
        do_instr(1'b0, 1'b0, 1'b0, 64'h0, 5, 2, 1'b1);
    endtask

    task automatic test_wrap();
        logic [63:0] wrap_imm;
        wrap_imm = (64'hFFFF_FFFF_FFFF_FFFC - addr_q[0]) >> 2;
        do_instr(1'b0, 1'b1, 1'b0, wrap_imm, 0, 0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 64'h0, 1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        int n;
        n = 0;
        while (IMemReq !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        IMemGnt = 1'b1;
        @(negedge CLK);
        IMemGnt = 1'b0;
        IMemRspValid = 1'b1;
        IMemRspData  = 32'h1234_5678;
        @(negedge CLK);
        IMemRspValid = 1'b0;
        checks++;
        if (InstValid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hold: InstValid=%b required 1", InstValid);
        end
        #2 Reset_L = 1'b0;
        #1;
        check_reset_outputs("reset_in_hold");
        @(negedge CLK);
        Reset_L      = 1'b1;
        IMemRspValid = 1'b1;
        IMemRspData  = 32'hBAD0_BAD0;
        @(negedge CLK);
        @(negedge CLK);
        IMemRspValid = 1'b0;
        addr_q.delete();
        inst_q.delete();
        addr_q.push_back(RESET_PC);
        exp_retire = '0;
        $display("reset pulsed in HOLD, stale response driven after release");
        do_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_stall_spurious();
        test_wrap();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
